// File: rtl/decode_stage_pipelined.sv
// -----------------------------------------------------------------------------
// decode_stage_pipelined
//
// RV32I-style decode stage that sits between fetch and execute. It contains:
//   - the architectural register file, with an optional same-cycle writeback
//     bypass on reads
//   - immediate generation for the I/S/B/U/J formats
//   - load-use hazard detection, which holds fetch and inserts a bubble
//   - a registered ID/EX stage with a valid/ready handshake and flush
//   - a saturating counter of stalled fetch cycles
//
// Ports
//   clk, rst              clock; asynchronous active-low reset
//   in_valid / in_ready   fetch -> decode handshake (in_ready is combinational)
//   instruction, pc       instruction word and its address
//   wb_*                  writeback port into the register file
//   ex_mem_read, ex_rd    load currently in EX, used for load-use detection
//   flush                 kills the ID/EX contents (taken branch / mispredict)
//   out_valid / out_ready ID/EX -> execute handshake
//   out_*                 registered decode results
//   stall_cycles          saturating count of cycles fetch was held
// -----------------------------------------------------------------------------
module decode_stage_pipelined #(
    parameter int XLEN      = 32,
    parameter int NUM_REGS  = 32,
    parameter int REG_ID_W  = $clog2(NUM_REGS),
    parameter bit BYPASS_WB = 1'b1,
    parameter bit HAZARD_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         instruction,
    input  logic [XLEN-1:0]     pc,
    input  logic                wb_reg_write,
    input  logic [REG_ID_W-1:0] wb_write_id,
    input  logic [XLEN-1:0]     wb_write_data,
    input  logic                ex_mem_read,
    input  logic [REG_ID_W-1:0] ex_rd,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_data1,
    output logic [XLEN-1:0]     out_data2,
    output logic [XLEN-1:0]     out_imm,
    output logic [REG_ID_W-1:0] out_rs1,
    output logic [REG_ID_W-1:0] out_rs2,
    output logic [REG_ID_W-1:0] out_rd,
    output logic [6:0]          out_opcode,
    output logic [2:0]          out_funct3,
    output logic [6:0]          out_funct7,
    output logic [XLEN-1:0]     out_pc,
    output logic [XLEN-1:0]     out_pc_branch,
    output logic                out_reg_write,
    output logic                out_mem_read,
    output logic                out_mem_write,
    output logic [31:0]         stall_cycles
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // ---------------------------------------------------------------------
    // Field extraction
    // ---------------------------------------------------------------------
    logic [6:0]          w_opcode;
    logic [2:0]          w_funct3;
    logic [6:0]          w_funct7;
    logic [REG_ID_W-1:0] w_rs1;
    logic [REG_ID_W-1:0] w_rs2;
    logic [REG_ID_W-1:0] w_rd;

    assign w_opcode = instruction[6:0];
    assign w_funct3 = instruction[14:12];
    assign w_funct7 = instruction[31:25];
    // The 5-bit ISA fields are resized to the register index width so that
    // smaller register files still decode (upper field bits are ignored).
    assign w_rs1    = REG_ID_W'(instruction[19:15]);
    assign w_rs2    = REG_ID_W'(instruction[24:20]);
    assign w_rd     = REG_ID_W'(instruction[11:7]);

    // ---------------------------------------------------------------------
    // Register file
    // ---------------------------------------------------------------------
    logic [XLEN-1:0] r_regs [NUM_REGS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wb_reg_write && (wb_write_id != '0)) begin
            r_regs[wb_write_id] <= wb_write_data;
        end
    end

    function automatic logic [XLEN-1:0] read_reg(input logic [REG_ID_W-1:0] idx);
        logic [XLEN-1:0] v;
        v = '0;
        if (idx != '0) begin
            if (BYPASS_WB && wb_reg_write && (wb_write_id == idx)) begin
                v = wb_write_data;
            end else begin
                v = r_regs[idx];
            end
        end
        return v;
    endfunction

    logic [XLEN-1:0] w_data1;
    logic [XLEN-1:0] w_data2;

    assign w_data1 = read_reg(w_rs1);
    assign w_data2 = read_reg(w_rs2);

    // ---------------------------------------------------------------------
    // Immediate generation: build the 32-bit RV32 immediate, then
    // sign-extend it to XLEN through a signed cast.
    // ---------------------------------------------------------------------
    logic signed [31:0] w_imm32;
    logic [XLEN-1:0]    w_imm;

    always_comb begin
        w_imm32 = '0;
        case (w_opcode)
            OP_I_ALU, OP_LOAD, OP_JALR:
                w_imm32 = {{20{instruction[31]}}, instruction[31:20]};
            OP_STORE:
                w_imm32 = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
            OP_BRANCH:
                w_imm32 = {{19{instruction[31]}}, instruction[31], instruction[7],
                           instruction[30:25], instruction[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                w_imm32 = {instruction[31:12], 12'b0};
            OP_JAL:
                w_imm32 = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                           instruction[20], instruction[30:21], 1'b0};
            default:
                w_imm32 = '0;
        endcase
    end

    assign w_imm = XLEN'(w_imm32);

    // ---------------------------------------------------------------------
    // Control decode
    // ---------------------------------------------------------------------
    logic w_reg_write;
    logic w_mem_read;
    logic w_mem_write;
    logic w_uses_rs1;
    logic w_uses_rs2;

    always_comb begin
        w_reg_write = 1'b0;
        case (w_opcode)
            OP_R, OP_I_ALU, OP_LOAD, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR:
                w_reg_write = (w_rd != '0);
            default:
                w_reg_write = 1'b0;
        endcase
    end

    assign w_mem_read  = (w_opcode == OP_LOAD);
    assign w_mem_write = (w_opcode == OP_STORE);
    assign w_uses_rs1  = !((w_opcode == OP_LUI) || (w_opcode == OP_AUIPC) ||
                           (w_opcode == OP_JAL));
    assign w_uses_rs2  = (w_opcode == OP_R) || (w_opcode == OP_STORE) ||
                         (w_opcode == OP_BRANCH);

    // ---------------------------------------------------------------------
    // Load-use hazard and fetch handshake
    // ---------------------------------------------------------------------
    logic w_hazard;
    logic w_accept;
    logic r_valid;

    assign w_hazard = HAZARD_EN && in_valid && ex_mem_read && (ex_rd != '0) &&
                      ((w_uses_rs1 && (w_rs1 == ex_rd)) ||
                       (w_uses_rs2 && (w_rs2 == ex_rd)));

    assign in_ready = !flush && !w_hazard && (!r_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    // ---------------------------------------------------------------------
    // ID/EX register. Flush wins over backpressure; a held entry blocks
    // everything else; a hazard or an idle cycle leaves a bubble. The payload
    // only changes on accept, so flushed or bubbled entries keep stale data
    // behind out_valid=0.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid       <= 1'b0;
            out_data1     <= '0;
            out_data2     <= '0;
            out_imm       <= '0;
            out_rs1       <= '0;
            out_rs2       <= '0;
            out_rd        <= '0;
            out_opcode    <= '0;
            out_funct3    <= '0;
            out_funct7    <= '0;
            out_pc        <= '0;
            out_pc_branch <= '0;
            out_reg_write <= 1'b0;
            out_mem_read  <= 1'b0;
            out_mem_write <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (r_valid && !out_ready) begin
            r_valid <= r_valid;
        end else if (w_hazard) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid       <= 1'b1;
            out_data1     <= w_data1;
            out_data2     <= w_data2;
            out_imm       <= w_imm;
            out_rs1       <= w_rs1;
            out_rs2       <= w_rs2;
            out_rd        <= w_rd;
            out_opcode    <= w_opcode;
            out_funct3    <= w_funct3;
            out_funct7    <= w_funct7;
            out_pc        <= pc;
            out_pc_branch <= pc + w_imm;
            out_reg_write <= w_reg_write;
            out_mem_read  <= w_mem_read;
            out_mem_write <= w_mem_write;
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid = r_valid;

    // ---------------------------------------------------------------------
    // Stall counter: cycles fetch offered an instruction that was refused for
    // a reason other than flush. Saturates instead of wrapping.
    // ---------------------------------------------------------------------
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cycles <= '0;
        end else if (in_valid && !in_ready && !flush && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_decode_stage_pipelined.sv
// -----------------------------------------------------------------------------
// Directed bench for decode_stage_pipelined. A second instance with the
// writeback bypass disabled shares all inputs so the bypass behaviour can be
// compared side by side.
// -----------------------------------------------------------------------------
module tb_decode_stage_pipelined;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        wb_reg_write;
    logic [4:0]  wb_write_id;
    logic [31:0] wb_write_data;
    logic        ex_mem_read;
    logic [4:0]  ex_rd;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data1, out_data2, out_imm, out_pc, out_pc_branch;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [6:0]  out_opcode, out_funct7;
    logic [2:0]  out_funct3;
    logic        out_reg_write, out_mem_read, out_mem_write;
    logic [31:0] stall_cycles;

    // outputs of the no-bypass instance
    logic        nb_in_ready, nb_out_valid;
    logic [31:0] nb_data1, nb_data2, nb_imm, nb_pc, nb_pc_branch;
    logic [4:0]  nb_rs1, nb_rs2, nb_rd;
    logic [6:0]  nb_opcode, nb_funct7;
    logic [2:0]  nb_funct3;
    logic        nb_reg_write, nb_mem_read, nb_mem_write;
    logic [31:0] nb_stall_cycles;

    int n_checks;
    int n_fail;

    decode_stage_pipelined #(.BYPASS_WB(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .pc(pc),
        .wb_reg_write(wb_reg_write), .wb_write_id(wb_write_id),
        .wb_write_data(wb_write_data),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data1(out_data1), .out_data2(out_data2), .out_imm(out_imm),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
        .out_pc(out_pc), .out_pc_branch(out_pc_branch),
        .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write), .stall_cycles(stall_cycles)
    );

    decode_stage_pipelined #(.BYPASS_WB(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(nb_in_ready),
        .instruction(instruction), .pc(pc),
        .wb_reg_write(wb_reg_write), .wb_write_id(wb_write_id),
        .wb_write_data(wb_write_data),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .flush(flush),
        .out_valid(nb_out_valid), .out_ready(out_ready),
        .out_data1(nb_data1), .out_data2(nb_data2), .out_imm(nb_imm),
        .out_rs1(nb_rs1), .out_rs2(nb_rs2), .out_rd(nb_rd),
        .out_opcode(nb_opcode), .out_funct3(nb_funct3), .out_funct7(nb_funct7),
        .out_pc(nb_pc), .out_pc_branch(nb_pc_branch),
        .out_reg_write(nb_reg_write), .out_mem_read(nb_mem_read),
        .out_mem_write(nb_mem_write), .stall_cycles(nb_stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b0;
        in_valid      = 1'b0;
        instruction   = '0;
        pc            = '0;
        wb_reg_write  = 1'b0;
        wb_write_id   = '0;
        wb_write_data = '0;
        ex_mem_read   = 1'b0;
        ex_rd         = '0;
        flush         = 1'b0;
        out_ready     = 1'b1;

        // ---- reset state
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_stall", stall_cycles, 32'd0);
        check("rst_data1", out_data1, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b1;

        // ---- write x5 = 0x1234, then addi x6,x5,-1
        wb_reg_write = 1'b1; wb_write_id = 5'd5; wb_write_data = 32'h1234;
        tick();
        wb_reg_write = 1'b0;
        in_valid = 1'b1; instruction = 32'hFFF28313; pc = 32'h100;
        #1;
        check("addi_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("addi_valid", 32'(out_valid), 32'd1);
        check("addi_data1", out_data1, 32'h1234);
        check("addi_imm", out_imm, 32'hFFFFFFFF);
        check("addi_rd", 32'(out_rd), 32'd6);
        check("addi_rs1", 32'(out_rs1), 32'd5);
        check("addi_reg_write", 32'(out_reg_write), 32'd1);
        check("addi_opcode", 32'(out_opcode), 32'h13);
        check("addi_pc", out_pc, 32'h100);
        tick();
        check("idle_valid", 32'(out_valid), 32'd0);

        // ---- same-cycle writeback x7 = 0xAA while decoding add x8,x7,x0
        wb_reg_write = 1'b1; wb_write_id = 5'd7; wb_write_data = 32'hAA;
        in_valid = 1'b1; instruction = 32'h00038433; pc = 32'h104;
        tick();
        wb_reg_write = 1'b0; in_valid = 1'b0;
        check("byp_data1", out_data1, 32'hAA);
        check("nobyp_data1", nb_data1, 32'd0);
        check("add_rd", 32'(out_rd), 32'd8);
        check("add_reg_write", 32'(out_reg_write), 32'd1);

        // ---- load-use hazard on rs2 (add x9,x7,x3 with load to x3 in EX)
        wb_reg_write = 1'b1; wb_write_id = 5'd3; wb_write_data = 32'h55;
        tick();
        wb_reg_write = 1'b0;
        in_valid = 1'b1; instruction = 32'h003384B3; pc = 32'h108;
        ex_mem_read = 1'b1; ex_rd = 5'd4;
        #1;
        check("nohaz_in_ready", 32'(in_ready), 32'd1);
        ex_rd = 5'd3;
        #1;
        check("haz_in_ready", 32'(in_ready), 32'd0);
        tick();
        check("haz_bubble", 32'(out_valid), 32'd0);
        check("haz_stall", stall_cycles, 32'd1);
        ex_mem_read = 1'b0;
        #1;
        check("haz_clear_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("haz_acc_valid", 32'(out_valid), 32'd1);
        check("haz_acc_data1", out_data1, 32'hAA);
        check("haz_acc_data2", out_data2, 32'h55);
        check("haz_acc_nb_data1", nb_data1, 32'hAA);
        check("haz_acc_rd", 32'(out_rd), 32'd9);
        check("haz_acc_stall", stall_cycles, 32'd1);

        // ---- branches: beq +0x10 then beq -8, back to back at pc 0x200
        in_valid = 1'b1; instruction = 32'h00000863; pc = 32'h200;
        tick();
        check("beq_p_imm", out_imm, 32'h10);
        check("beq_p_target", out_pc_branch, 32'h210);
        check("beq_p_reg_write", 32'(out_reg_write), 32'd0);
        instruction = 32'hFE000CE3;
        tick();
        check("beq_n_valid", 32'(out_valid), 32'd1);
        check("beq_n_imm", out_imm, 32'hFFFFFFF8);
        check("beq_n_target", out_pc_branch, 32'h1F8);

        // ---- backpressure for 3 cycles with lui x1,0x12345 waiting
        out_ready = 1'b0; instruction = 32'h123450B7; pc = 32'h300;
        #1;
        check("bp_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) tick();
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_imm_held", out_imm, 32'hFFFFFFF8);
        check("bp_pc_held", out_pc, 32'h200);
        check("bp_stall", stall_cycles, 32'd4);

        // ---- flush kills the held entry and does not count as a stall
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_stall", stall_cycles, 32'd4);
        check("flush_payload_held", out_pc_branch, 32'h1F8);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("lui_valid", 32'(out_valid), 32'd1);
        check("lui_imm", out_imm, 32'h12345000);
        check("lui_mem_read", 32'(out_mem_read), 32'd0);
        check("lui_mem_write", 32'(out_mem_write), 32'd0);
        check("lui_rd", 32'(out_rd), 32'd1);

        // ---- x0: write attempt with same-cycle read, then plain read
        wb_reg_write = 1'b1; wb_write_id = 5'd0; wb_write_data = 32'hFFFF;
        in_valid = 1'b1; instruction = 32'h00000113; pc = 32'h400;
        tick();
        wb_reg_write = 1'b0;
        check("x0_byp_data1", out_data1, 32'd0);
        check("x0_reg_write", 32'(out_reg_write), 32'd1);
        tick();
        in_valid = 1'b0;
        check("x0_read_data1", out_data1, 32'd0);

        // ---- store sw x5,-4(x6) and load lw x10,8(x5)
        in_valid = 1'b1; instruction = 32'hFE532E23; pc = 32'h500;
        tick();
        check("sw_imm", out_imm, 32'hFFFFFFFC);
        check("sw_mem_write", 32'(out_mem_write), 32'd1);
        check("sw_reg_write", 32'(out_reg_write), 32'd0);
        check("sw_data2", out_data2, 32'h1234);
        instruction = 32'h0082A503;
        tick();
        in_valid = 1'b0;
        check("lw_imm", out_imm, 32'd8);
        check("lw_mem_read", 32'(out_mem_read), 32'd1);
        check("lw_data1", out_data1, 32'h1234);
        check("lw_funct3", 32'(out_funct3), 32'd2);

        // ---- asynchronous reset while holding a live entry
        #3;
        rst = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_stall", stall_cycles, 32'd0);
        check("async_rst_imm", out_imm, 32'd0);
        rst = 1'b1;

        // register file must also be cleared: read x5 after reset
        in_valid = 1'b1; instruction = 32'hFFF28313; pc = 32'h100;
        tick();
        in_valid = 1'b0;
        check("post_rst_x5", out_data1, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
